// File: rtl/fpm_round.sv
// fpm_round: two-stage normalise / round / exception pipeline for the FP16 multiplier.
// Define FPM_RNE_EN for round-to-nearest-even; leave it undefined for truncation.
module fpm_round (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic signed [6:0] in_exp,
    input  logic [21:0]       in_prod,
    input  logic              in_nan,
    input  logic              in_inf,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [4:0]        out_exp,
    output logic [9:0]        out_man,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_inexact
);

    logic              vld_p1_q;
    logic              sign_p1_q;
    logic signed [7:0] exp_p1_q;
    logic [9:0]        frac_p1_q;
    logic              g_p1_q;
    logic              sticky_p1_q;
    logic              inc_p1_q;
    logic              nan_p1_q;
    logic              inf_p1_q;
    logic              zero_p1_q;

    logic              vld_p2_q;
    logic [18:0]       res_p2_q;
    logic [18:0]       res_d;

    logic              adv1;
    logic              adv2;

    logic signed [7:0] exp_d;
    logic [9:0]        frac_d;
    logic              g_d;
    logic              sticky_d;
    logic              inc_d;

`ifdef FPM_RNE_EN
    function automatic logic rne_inc(input logic lsb, input logic g, input logic sticky);
        return g & (sticky | lsb);
    endfunction
`endif

    // Result layout: {sign, exp[4:0], man[9:0], ovf, unf, inexact}.
    function automatic logic [18:0] round_pack(
        input logic              sign,
        input logic signed [7:0] exp,
        input logic [9:0]        frac,
        input logic              inc,
        input logic              g,
        input logic              sticky,
        input logic              nan,
        input logic              inf,
        input logic              zero
    );
        logic [10:0]       sum;
        logic signed [7:0] e;
        logic [9:0]        man;
        logic              inx;
        sum = {1'b0, frac} + {10'd0, inc};
        e   = exp + $signed({7'd0, sum[10]});
        man = sum[10] ? 10'd0 : sum[9:0];
        inx = g | sticky;
        if (nan)
            return {1'b0, 5'd31, 10'h200, 3'b000};
        else if (inf)
            return {sign, 5'd31, 10'd0, 3'b000};
        else if (zero)
            return {sign, 5'd0, 10'd0, 3'b000};
        else if (e >= 8'sd31)
            return {sign, 5'd31, 10'd0, 1'b1, 1'b0, inx};
        else if (e <= 8'sd0)
            return {sign, 5'd0, 10'd0, 1'b0, 1'b1, inx};
        else
            return {sign, e[4:0], man, 1'b0, 1'b0, inx};
    endfunction

    assign adv2     = !vld_p2_q | out_ready;
    assign adv1     = !vld_p1_q | adv2;
    assign in_ready = adv1;

    always_comb begin
        if (in_prod[21]) begin
            frac_d   = in_prod[20:11];
            g_d      = in_prod[10];
            sticky_d = |in_prod[9:0];
            exp_d    = $signed({in_exp[6], in_exp}) + 8'sd1;
        end else begin
            frac_d   = in_prod[19:10];
            g_d      = in_prod[9];
            sticky_d = |in_prod[8:0];
            exp_d    = $signed({in_exp[6], in_exp});
        end
`ifdef FPM_RNE_EN
        inc_d = rne_inc(frac_d[0], g_d, sticky_d);
`else
        inc_d = 1'b0;
`endif
    end

    // Stage 1 boundary: normalised fraction, exponent and rounding bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1_q <= 1'b0;
        else if (adv1)
            vld_p1_q <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid && adv1) begin
            sign_p1_q   <= in_sign;
            exp_p1_q    <= exp_d;
            frac_p1_q   <= frac_d;
            g_p1_q      <= g_d;
            sticky_p1_q <= sticky_d;
            inc_p1_q    <= inc_d;
            nan_p1_q    <= in_nan;
            inf_p1_q    <= in_inf;
            zero_p1_q   <= in_zero;
        end
    end

    assign res_d = round_pack(sign_p1_q, exp_p1_q, frac_p1_q, inc_p1_q, g_p1_q,
                              sticky_p1_q, nan_p1_q, inf_p1_q, zero_p1_q);

    // Stage 2 boundary: packed result; cleared on reset so outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q <= 1'b0;
            res_p2_q <= '0;
        end else if (adv2) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q)
                res_p2_q <= res_d;
        end
    end

    assign out_valid   = vld_p2_q;
    assign out_sign    = res_p2_q[18];
    assign out_exp     = res_p2_q[17:13];
    assign out_man     = res_p2_q[12:3];
    assign out_ovf     = res_p2_q[2];
    assign out_unf     = res_p2_q[1];
    assign out_inexact = res_p2_q[0];

endmodule
